// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg
// Shared definitions for the multicycle MIPS control path: instruction
// opcode/funct constants, ALU operation codes, datapath mux-select codes
// and the 4-bit FSM state type. The state type's values are the ones
// exported on state_out.

package mips_ctrl_pkg;

  // Opcodes, IR[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes, IR[5:0]
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  // ALU operations
  localparam logic [2:0] ALU_NONE = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_SLT  = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;

  // Memory address select
  localparam logic IORD_PC     = 1'b0;
  localparam logic IORD_ALUOUT = 1'b1;

  // ALU A-operand select
  localparam logic SRCA_PC = 1'b0;
  localparam logic SRCA_A  = 1'b1;

  // ALU B-operand select
  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // Register-file write address select
  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  // Register-file write data select
  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_A      = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_RTYPE_WB  = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_JAL       = 4'd10,
    S_XORI_EXEC = 4'd11,
    S_XORI_WB   = 4'd12,
    S_JR        = 4'd13,
    S_ILLEGAL   = 4'd14
  } state_t;

  // ALU operation for the arithmetic R-type functions; ALU_NONE marks a
  // funct that is not one of them.
  function automatic logic [2:0] rtype_alu_op(input logic [5:0] funct);
    case (funct)
      FN_ADD:  return ALU_ADD;
      FN_SUB:  return ALU_SUB;
      FN_SLT:  return ALU_SLT;
      default: return ALU_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// ctrl_output_decode
// Purely combinational map from the control FSM state to the datapath
// control word. funct is consulted only in EXEC_R to pick the ALU op.
// PC loading is reported as the raw pc_write / pc_write_cond pair; the
// branch condition is folded in by the parent.
//
// Ports:
//   state          in  4  current FSM state (state_t encoding)
//   funct          in  6  IR[5:0]
//   pc_write       out 1  unconditional PC load
//   pc_write_cond  out 1  PC load when the ALU result is non-zero (bne)
//   i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
//   reg_write, alu_src_a, alu_src_b, alu_op, pc_source
//                  out    datapath controls, encodings in mips_ctrl_pkg

module ctrl_output_decode
  import mips_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic [5:0] funct,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_source
);

  state_t st;
  assign st = state_t'(state);

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = IORD_PC;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = REGDST_RT;
    mem_to_reg    = WB_ALUOUT;
    reg_write     = 1'b0;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_B;
    alu_op        = ALU_NONE;
    pc_source     = PCSRC_ALU;

    case (st)
      S_FETCH: begin
        // IR <= Mem[PC]; PC <= PC + 4
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_op    = ALU_ADD;
        alu_src_b = SRCB_FOUR;
        pc_source = PCSRC_ALU;
        pc_write  = 1'b1;
      end
      S_DECODE: begin
        // Speculative branch target into ALUOut
        alu_op    = ALU_ADD;
        alu_src_b = SRCB_IMM_SH2;
      end
      S_MEM_ADDR: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ADD;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = IORD_ALUOUT;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        reg_dst    = REGDST_RT;
        mem_to_reg = WB_MDR;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = IORD_ALUOUT;
      end
      S_EXEC_R: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_B;
        alu_op    = rtype_alu_op(funct);
      end
      S_RTYPE_WB: begin
        reg_write  = 1'b1;
        reg_dst    = REGDST_RD;
        mem_to_reg = WB_ALUOUT;
      end
      S_XORI_EXEC: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_XOR;
      end
      S_XORI_WB: begin
        reg_write = 1'b1;
        reg_dst   = REGDST_RT;
      end
      S_BRANCH: begin
        // A - B; the target computed in DECODE sits in ALUOut
        alu_src_a     = SRCA_A;
        alu_src_b     = SRCB_B;
        alu_op        = ALU_SUB;
        pc_source     = PCSRC_ALUOUT;
        pc_write_cond = 1'b1;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      S_JAL: begin
        // PC already holds PC+4; the register write sees it before the
        // jump target lands at the end of this cycle.
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        reg_write  = 1'b1;
        reg_dst    = REGDST_RA;
        mem_to_reg = WB_PC;
      end
      S_JR: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_A;
      end
      default: begin
        // ILLEGAL and unused encodings drive nothing
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control
// Moore control FSM for the shared multicycle MIPS datapath (add, sub,
// slt, jr, xori, bne, j, jal, lw, sw) plus a retired-instruction counter.
// Outputs are decoded from the state register by ctrl_output_decode;
// pc_en additionally folds in alu_zero for bne.
//
// Configuration macro ILLEGAL_TRAP_EN:
//   defined   - ILLEGAL is a sink left only by reset; illegal_instr port
//               flags it and the trapped instruction is not counted.
//   undefined - ILLEGAL is a one-cycle NOP that retires normally; no
//               illegal_instr port.
//
// Ports:
//   clk            in  1          rising-edge clock
//   reset          in  1          synchronous, active-high
//   opcode         in  6          IR[31:26], valid from DECODE onward
//   funct          in  6          IR[5:0]
//   alu_zero       in  1          ALU zero flag
//   pc_en          out 1          PC load enable
//   i_or_d .. pc_source  out      datapath controls (see mips_ctrl_pkg)
//   illegal_instr  out 1          in ILLEGAL (ILLEGAL_TRAP_EN only)
//   state_out      out 4          current state encoding
//   retired_count  out CNT_WIDTH  completed instructions, wraps

module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 alu_zero,
  output logic                 pc_en,
  output logic                 i_or_d,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic [1:0]           reg_dst,
  output logic [1:0]           mem_to_reg,
  output logic                 reg_write,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [2:0]           alu_op,
  output logic [1:0]           pc_source,
`ifdef ILLEGAL_TRAP_EN
  output logic                 illegal_instr,
`endif
  output logic [3:0]           state_out,
  output logic [CNT_WIDTH-1:0] retired_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t state;
  state_t next_state;
  logic   pc_write;
  logic   pc_write_cond;

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH: next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next_state = S_MEM_ADDR;
          OP_RTYPE: begin
            if (rtype_alu_op(funct) != ALU_NONE) next_state = S_EXEC_R;
            else if (funct == FN_JR)             next_state = S_JR;
            else                                 next_state = S_ILLEGAL;
          end
          OP_XORI: next_state = S_XORI_EXEC;
          OP_BNE:  next_state = S_BRANCH;
          OP_J:    next_state = S_JUMP;
          OP_JAL:  next_state = S_JAL;
          default: next_state = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR:  next_state = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  next_state = S_MEM_WB;
      S_EXEC_R:    next_state = S_RTYPE_WB;
      S_XORI_EXEC: next_state = S_XORI_WB;
`ifdef ILLEGAL_TRAP_EN
      S_ILLEGAL:   next_state = S_ILLEGAL;
`else
      S_ILLEGAL:   next_state = S_FETCH;
`endif
      // All remaining states are the last step of an instruction
      default:     next_state = S_FETCH;
    endcase
  end

  // Every entry into FETCH closes an instruction, since FETCH itself
  // always moves on to DECODE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_FETCH;
      retired_count <= '0;
    end else begin
      state <= next_state;
      if (next_state == S_FETCH) retired_count <= retired_count + CNT_ONE;
    end
  end

  ctrl_output_decode u_decode (
    .state         (state),
    .funct         (funct),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source)
  );

  // bne is taken when A - B is non-zero
  assign pc_en     = pc_write | (pc_write_cond & ~alu_zero);
  assign state_out = state;

`ifdef ILLEGAL_TRAP_EN
  assign illegal_instr = (state == S_ILLEGAL);
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
// Drives instruction opcodes/functs into multicycle_control and compares
// the per-cycle control word and the retired count against a model that
// derives each instruction's step list and per-step controls directly
// from the instruction set description. The counter is narrowed to 4
// bits so the random run also crosses the wrap-around.

module tb_multicycle_control;

  localparam int TB_CNT_W = 4;

  localparam logic [5:0] T_R    = 6'b000000;
  localparam logic [5:0] T_XORI = 6'b001110;
  localparam logic [5:0] T_BNE  = 6'b000101;
  localparam logic [5:0] T_J    = 6'b000010;
  localparam logic [5:0] T_JAL  = 6'b000011;
  localparam logic [5:0] T_LW   = 6'b100011;
  localparam logic [5:0] T_SW   = 6'b101011;
  localparam logic [5:0] T_BAD  = 6'b111111;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_JR   = 6'b001000;
  localparam logic [5:0] F_BAD  = 6'b000001;

  logic                clk = 1'b0;
  logic                reset;
  logic [5:0]          opcode;
  logic [5:0]          funct;
  logic                alu_zero;
  logic                pc_en, i_or_d, mem_read, mem_write, ir_write;
  logic [1:0]          reg_dst, mem_to_reg;
  logic                reg_write, alu_src_a;
  logic [1:0]          alu_src_b;
  logic [2:0]          alu_op;
  logic [1:0]          pc_source;
  logic [3:0]          state_out;
  logic [TB_CNT_W-1:0] retired_count;
`ifdef ILLEGAL_TRAP_EN
  logic                illegal_instr;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int model_cnt = 0;
  logic exp_retire;
  logic [21:0] obs_q[$];
  logic [21:0] exp_q[$];

  always #5 clk = ~clk;

  multicycle_control #(.CNT_WIDTH(TB_CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .funct         (funct),
    .alu_zero      (alu_zero),
    .pc_en         (pc_en),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
`ifdef ILLEGAL_TRAP_EN
    .illegal_instr (illegal_instr),
`endif
    .state_out     (state_out),
    .retired_count (retired_count)
  );

  // {state, pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst,
  //  mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source}
  function automatic logic [21:0] obs_word();
    return {state_out, pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst,
            mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};
  endfunction

  // Control word each step should present, straight from the step table.
  function automatic logic [21:0] model_word(input int st, input logic [5:0] fn,
                                             input logic z);
    logic pw, pwc, iod, mr, mw, irw, rw, sa;
    logic [1:0] rd, m2r, sb, ps;
    logic [2:0] op;
    logic [3:0] s4;
    {pw, pwc, iod, mr, mw, irw, rw, sa} = '0;
    {rd, m2r, sb, ps} = '0;
    op = 3'd0;
    s4 = 4'(st);
    case (st)
      0:  begin mr = 1; irw = 1; op = 3'd1; sb = 2'd1; pw = 1; end
      1:  begin op = 3'd1; sb = 2'd3; end
      2:  begin sa = 1; sb = 2'd2; op = 3'd1; end
      3:  begin mr = 1; iod = 1; end
      4:  begin rw = 1; m2r = 2'd1; end
      5:  begin mw = 1; iod = 1; end
      6:  begin
            sa = 1;
            op = (fn == F_SUB) ? 3'd2 : (fn == F_SLT) ? 3'd3 : 3'd1;
          end
      7:  begin rw = 1; rd = 2'd1; end
      8:  begin sa = 1; op = 3'd2; ps = 2'd1; pwc = 1; end
      9:  begin pw = 1; ps = 2'd2; end
      10: begin pw = 1; ps = 2'd2; rw = 1; rd = 2'd2; m2r = 2'd2; end
      11: begin sa = 1; sb = 2'd2; op = 3'd4; end
      12: begin rw = 1; end
      13: begin pw = 1; ps = 2'd3; end
      default: ;
    endcase
    return {s4, pw | (pwc & ~z), iod, mr, mw, irw, rd, m2r, rw, sa, sb, op, ps};
  endfunction

  // Step list of one instruction, as control words, into exp_q.
  task automatic build_expected(input logic [5:0] op, input logic [5:0] fn,
                                input logic z);
    int path[$];
    exp_retire = 1'b1;
    if (op == T_LW) path = '{0, 1, 2, 3, 4};
    else if (op == T_SW) path = '{0, 1, 2, 5};
    else if (op == T_R && (fn == F_ADD || fn == F_SUB || fn == F_SLT)) path = '{0, 1, 6, 7};
    else if (op == T_R && fn == F_JR) path = '{0, 1, 13};
    else if (op == T_XORI) path = '{0, 1, 11, 12};
    else if (op == T_BNE) path = '{0, 1, 8};
    else if (op == T_J) path = '{0, 1, 9};
    else if (op == T_JAL) path = '{0, 1, 10};
    else begin
`ifdef ILLEGAL_TRAP_EN
      path = '{0, 1};
      for (int k = 0; k < 10; k++) path.push_back(14);
      exp_retire = 1'b0;
`else
      path = '{0, 1, 14};
`endif
    end
    exp_q.delete();
    foreach (path[k]) exp_q.push_back(model_word(path[k], fn, z));
  endtask

  // Entered just after a rising edge with the DUT in FETCH; records one
  // control word per cycle until the DUT is back in FETCH or the budget
  // runs out, and returns just after a rising edge.
  task automatic drive_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int budget);
    obs_q.delete();
    opcode = op;
    funct = fn;
    alu_zero = z;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      obs_q.push_back(obs_word());
      @(posedge clk);
      #1;
      if (state_out == 4'd0) break;
    end
  endtask

  task automatic apply_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
    model_cnt = 0;
  endtask

  task automatic test_reset();
    opcode = 6'd0;
    funct = 6'd0;
    alu_zero = 1'b0;
    apply_reset(2);
    n_checks++;
    if (obs_word() !== model_word(0, 6'd0, 1'b0)) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %h expected %h", obs_word(), model_word(0, 6'd0, 1'b0));
    end
    n_checks++;
    if ({state_out, mem_read, ir_write, pc_en} !== 7'b0000_111) begin
      n_fail++;
      $display("FAIL reset_fetch: state %0d mem_read %b ir_write %b pc_en %b expected 0 1 1 1",
               state_out, mem_read, ir_write, pc_en);
    end
    n_checks++;
    if (retired_count !== '0) begin
      n_fail++;
      $display("FAIL reset_count: got %0d expected 0", retired_count);
    end
  endtask

  task automatic test_lw();
    build_expected(T_LW, 6'h2a, 1'b0);
    drive_instr(T_LW, 6'h2a, 1'b0, 8);
    model_cnt = (model_cnt + 1) % (1 << TB_CNT_W);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL lw_cycles: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL lw_step%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (retired_count !== TB_CNT_W'(model_cnt)) begin
      n_fail++;
      $display("FAIL lw_count: got %0d expected %0d", retired_count, model_cnt);
    end
  endtask

  task automatic test_bne();
    for (int t = 0; t < 2; t++) begin
      logic z;
      z = (t == 0);
      build_expected(T_BNE, 6'h15, z);
      drive_instr(T_BNE, 6'h15, z, 8);
      model_cnt = (model_cnt + 1) % (1 << TB_CNT_W);
      n_checks++;
      if (obs_q.size() != 3) begin
        n_fail++;
        $display("FAIL bne_cycles zero=%b: got %0d expected 3", z, obs_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL bne_step%0d zero=%b: got %h expected %h", i, z, obs_q[i], exp_q[i]);
        end
      end
      n_checks++;
      if (retired_count !== TB_CNT_W'(model_cnt)) begin
        n_fail++;
        $display("FAIL bne_count: got %0d expected %0d", retired_count, model_cnt);
      end
    end
  endtask

  task automatic test_sub_jal();
    logic [5:0] ops[2];
    logic [5:0] fns[2];
    ops = '{T_R, T_JAL};
    fns = '{F_SUB, 6'h3f};
    apply_reset(1);
    for (int t = 0; t < 2; t++) begin
      build_expected(ops[t], fns[t], 1'b1);
      drive_instr(ops[t], fns[t], 1'b1, 8);
      model_cnt = (model_cnt + 1) % (1 << TB_CNT_W);
      n_checks++;
      if (obs_q.size() != exp_q.size()) begin
        n_fail++;
        $display("FAIL subjal_cycles%0d: got %0d expected %0d", t, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL subjal%0d_step%0d: got %h expected %h", t, i, obs_q[i], exp_q[i]);
        end
      end
    end
    n_checks++;
    if (retired_count !== TB_CNT_W'(2)) begin
      n_fail++;
      $display("FAIL subjal_count: got %0d expected 2", retired_count);
    end
  endtask

  task automatic test_reset_mid_sw();
    logic saw_write;
    saw_write = 1'b0;
    opcode = T_SW;
    funct = 6'd0;
    alu_zero = 1'b0;
    repeat (2) begin
      @(negedge clk);
      saw_write |= mem_write;
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (state_out !== 4'd2) begin
      n_fail++;
      $display("FAIL midsw_addr_state: got %0d expected 2", state_out);
    end
    @(negedge clk);
    saw_write |= mem_write;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_cnt = 0;
    saw_write |= mem_write;
    n_checks++;
    if (state_out !== 4'd0) begin
      n_fail++;
      $display("FAIL midsw_state: got %0d expected 0", state_out);
    end
    @(negedge clk);
    saw_write |= mem_write;
    n_checks++;
    if (saw_write !== 1'b0) begin
      n_fail++;
      $display("FAIL midsw_mem_write: got %b expected 0", saw_write);
    end
    n_checks++;
    if (retired_count !== '0) begin
      n_fail++;
      $display("FAIL midsw_count: got %0d expected 0", retired_count);
    end
    // Resynchronise just after the next edge, then run sw to completion
    @(posedge clk);
    #1;
    n_checks++;
    if (state_out !== 4'd1) begin
      n_fail++;
      $display("FAIL midsw_resume: got %0d expected 1", state_out);
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    model_cnt = 1;
    n_checks++;
    if (state_out !== 4'd0 || retired_count !== TB_CNT_W'(model_cnt)) begin
      n_fail++;
      $display("FAIL midsw_rerun: state %0d count %0d expected 0 and %0d",
               state_out, retired_count, model_cnt);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops[12];
    logic [5:0] fns[12];
    ops = '{T_LW, T_SW, T_R, T_R, T_R, T_R, T_XORI, T_BNE, T_J, T_JAL, T_BAD, T_R};
    fns = '{6'd0, 6'd0, F_ADD, F_SUB, F_SLT, F_JR, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, F_BAD};
    for (int n = 0; n < 40; n++) begin
      int k;
      logic [5:0] op, fn;
      logic z;
`ifdef ILLEGAL_TRAP_EN
      k = $urandom_range(9, 0);
`else
      k = $urandom_range(11, 0);
`endif
      op = ops[k];
      fn = (op == T_R) ? fns[k] : 6'($urandom);
      z = 1'($urandom);
      build_expected(op, fn, z);
      drive_instr(op, fn, z, 8);
      if (exp_retire) model_cnt = (model_cnt + 1) % (1 << TB_CNT_W);
      n_checks++;
      if (obs_q.size() != exp_q.size()) begin
        n_fail++;
        $display("FAIL rand%0d_cycles op=%b fn=%b: got %0d expected %0d",
                 n, op, fn, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL rand%0d_step%0d op=%b fn=%b z=%b: got %h expected %h",
                   n, i, op, fn, z, obs_q[i], exp_q[i]);
        end
      end
      n_checks++;
      if (retired_count !== TB_CNT_W'(model_cnt)) begin
        n_fail++;
        $display("FAIL rand%0d_count: got %0d expected %0d", n, retired_count, model_cnt);
      end
    end
  endtask

  task automatic test_illegal();
    logic [5:0] ops[2];
    logic [5:0] fns[2];
    ops = '{T_BAD, T_R};
    fns = '{6'd0, F_BAD};
    for (int t = 0; t < 2; t++) begin
      apply_reset(1);
      build_expected(ops[t], fns[t], 1'b0);
      drive_instr(ops[t], fns[t], 1'b0, 12);
      if (exp_retire) model_cnt = model_cnt + 1;
      n_checks++;
      if (obs_q.size() != exp_q.size()) begin
        n_fail++;
        $display("FAIL illegal%0d_cycles: got %0d expected %0d", t, obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL illegal%0d_step%0d: got %h expected %h", t, i, obs_q[i], exp_q[i]);
        end
      end
      n_checks++;
      if (retired_count !== TB_CNT_W'(model_cnt)) begin
        n_fail++;
        $display("FAIL illegal%0d_count: got %0d expected %0d", t, retired_count, model_cnt);
      end
`ifdef ILLEGAL_TRAP_EN
      n_checks++;
      if (illegal_instr !== 1'b1 || state_out !== 4'd14) begin
        n_fail++;
        $display("FAIL illegal%0d_flag: illegal_instr %b state %0d expected 1 and 14",
                 t, illegal_instr, state_out);
      end
`endif
    end
    apply_reset(1);
    n_checks++;
    if (state_out !== 4'd0 || retired_count !== '0) begin
      n_fail++;
      $display("FAIL illegal_exit: state %0d count %0d expected 0 and 0", state_out, retired_count);
    end
`ifdef ILLEGAL_TRAP_EN
    n_checks++;
    if (illegal_instr !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_exit_flag: got %b expected 0", illegal_instr);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_lw();
    test_bne();
    test_sub_jal();
    test_reset_mid_sw();
    test_random();
    test_illegal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
